// File: rtl/mult_seq_pkg.sv
// Shared definitions for the multiplier operand sequencer: FSM encoding,
// width helpers and the product-taint prefix function.
package mult_seq_pkg;

  localparam int SEQ_NUM_BITS = 7;
  localparam int PW           = 2 * SEQ_NUM_BITS;  // product width
  localparam int JW           = 4 * SEQ_NUM_BITS;  // queued job width

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RST     = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

  // Bit i of the product depends on operand bits 0..min(i,N-1), so its taint
  // is the OR of the combined operand taint over that low range.
  function automatic logic [PW-1:0] taint_prefix(input logic [SEQ_NUM_BITS-1:0] t);
    logic [PW-1:0] r;
    logic          acc;
    acc = 1'b0;
    r   = {PW{1'b0}};
    for (int i = 0; i < SEQ_NUM_BITS; i++) begin
      acc  = acc | t[i];
      r[i] = acc;
    end
    for (int i = SEQ_NUM_BITS; i < PW; i++) begin
      r[i] = acc;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_seq_fifo.sv
// Synchronous job FIFO with full/empty flags; pointers carry one wrap bit.
module mult_seq_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q[AW-1:0]];

  // Advance read/write pointers on accepted push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents are don't-care until a slot is pushed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Issue stage for the constant-time taint-tracking multiplier: queues jobs,
// drives reset/start/wait on the multiplier and returns product plus taint.
module mult_operand_sequencer
  import mult_seq_pkg::*;
#(
  parameter int NUM_BITS     = SEQ_NUM_BITS,
  parameter int FIFO_DEPTH   = 4,
  parameter int MULT_LATENCY = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BITS-1:0]   in_multiplier,
  input  logic [NUM_BITS-1:0]   in_multiplicand,
  input  logic [NUM_BITS-1:0]   in_mplier_taint,
  input  logic [NUM_BITS-1:0]   in_mcand_taint,
  output logic                  mul_rst,
  output logic                  mul_start,
  output logic [NUM_BITS-1:0]   mul_multiplier,
  output logic [NUM_BITS-1:0]   mul_multiplicand,
  input  logic [2*NUM_BITS-1:0] mul_product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NUM_BITS-1:0] out_product,
  output logic [2*NUM_BITS-1:0] out_taint,
  output logic                  busy
);

  localparam int              CW       = $clog2(MULT_LATENCY + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(MULT_LATENCY - 1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [JW-1:0]         fifo_rdata;
  logic                  capture_s;
  logic                  slot_free_s;
  logic                  mul_rst_q, mul_rst_d;
  logic                  mul_start_q, mul_start_d;
  logic                  out_valid_q, out_valid_d;
  logic [NUM_BITS-1:0]   mplier_q, mcand_q, taint_q;
  logic [PW-1:0]         out_product_q, out_taint_q;

  mult_seq_fifo #(
    .WIDTH (JW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata ({in_multiplier, in_multiplicand, in_mplier_taint, in_mcand_taint}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready         = !fifo_full;
  assign slot_free_s      = !out_valid_q || out_ready;
  assign mul_rst          = mul_rst_q;
  assign mul_start        = mul_start_q;
  assign mul_multiplier   = mplier_q;
  assign mul_multiplicand = mcand_q;
  assign out_valid        = out_valid_q;
  assign out_product      = out_product_q;
  assign out_taint        = out_taint_q;
  assign busy             = (state_q != ST_IDLE) || !fifo_empty || out_valid_q;

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the wait length is fixed so latency is data independent.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fifo_pop  = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_RST;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RST:   state_d = ST_START;
      ST_START: begin
        cnt_d   = CNT_INIT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          if (slot_free_s) begin
            capture_s = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d   = ST_CAPTURE;
          end
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_CAPTURE: begin
        if (slot_free_s) begin
          capture_s = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d   = ST_CAPTURE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: multiplier strobes follow the next state so they are registered.
  always_comb begin
    mul_rst_d   = (state_d == ST_RST);
    mul_start_d = (state_d == ST_START);
    if (capture_s) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath: operand hold registers, multiplier strobes and result slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_rst_q     <= 1'b1;
      mul_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      mplier_q      <= {NUM_BITS{1'b0}};
      mcand_q       <= {NUM_BITS{1'b0}};
      taint_q       <= {NUM_BITS{1'b0}};
      out_product_q <= {PW{1'b0}};
      out_taint_q   <= {PW{1'b0}};
    end else begin
      mul_rst_q   <= mul_rst_d;
      mul_start_q <= mul_start_d;
      out_valid_q <= out_valid_d;
      if (fifo_pop) begin
        mplier_q <= fifo_rdata[4*NUM_BITS-1:3*NUM_BITS];
        mcand_q  <= fifo_rdata[3*NUM_BITS-1:2*NUM_BITS];
        taint_q  <= fifo_rdata[2*NUM_BITS-1:NUM_BITS] | fifo_rdata[NUM_BITS-1:0];
      end
      if (capture_s) begin
        out_product_q <= mul_product;
        out_taint_q   <= taint_prefix(taint_q);
      end
    end
  end

endmodule
